// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with level tracking, threshold flags,
// error pulses, synchronous flush and an optional output register stage.
//
// Parameters:
//   DATA_WIDTH       width of wr_data / rd_data (1..256)
//   ADDR_WIDTH       pointer width, DEPTH = 2**ADDR_WIDTH (4..10)
//   OUT_REG          1 adds a register stage after the storage read
//   ALMOST_FULL_NUM  almost_full when water_level >= this (1..DEPTH)
//   ALMOST_EMPTY_NUM almost_empty when water_level <= this (0..DEPTH-1)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear, overrides wr_en / rd_en
//   wr_en, wr_data        write request and data
//   rd_en                 read request
//   rd_data, rd_valid     read data and its one-cycle valid strobe
//   full, empty           level == DEPTH / level == 0
//   almost_full/empty     threshold flags
//   water_level           stored word count, 0..DEPTH
//   overflow, underflow   one-cycle pulses after a write-when-full / read-when-empty
module param_sync_fifo #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 4,
    parameter int OUT_REG          = 0,
    parameter int ALMOST_FULL_NUM  = 11,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AF_I  = ALMOST_FULL_NUM;
    localparam int AE_I  = ALMOST_EMPTY_NUM;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] L_AF    = AF_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] L_AE    = AE_I[ADDR_WIDTH:0];

    generate
        if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_err_dw
            $error("param_sync_fifo: DATA_WIDTH out of range 1..256");
        end
        if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10) begin : g_err_aw
            $error("param_sync_fifo: ADDR_WIDTH out of range 4..10");
        end
        if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH) begin : g_err_af
            $error("param_sync_fifo: ALMOST_FULL_NUM out of range 1..DEPTH");
        end
        if (ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_err_ae
            $error("param_sync_fifo: ALMOST_EMPTY_NUM out of range 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Flags come only from the registered level.
    assign w_full  = (r_level == L_DEPTH);
    assign w_empty = (r_level == '0);

    // Flush masks both requests; a read is judged against the pre-write
    // level, so an empty FIFO never forwards a same-cycle write.
    assign w_wr_acc = wr_en & ~w_full  & ~flush;
    assign w_rd_acc = rd_en & ~w_empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= ~flush & wr_en & w_full;
            r_underflow <= ~flush & rd_en & w_empty;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_wr_acc)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd_acc)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_wr_acc && !w_rd_acc)
                    r_level <= r_level + 1'b1;
                else if (w_rd_acc && !w_wr_acc)
                    r_level <= r_level - 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= wr_data;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_s1_data;
            logic                  r_s1_valid;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_data  <= '0;
                    r_s1_valid <= 1'b0;
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush) begin
                    r_s1_valid <= 1'b0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_s1_valid <= w_rd_acc;
                    if (w_rd_acc)
                        r_s1_data <= r_mem[r_rd_ptr];
                    r_rd_valid <= r_s1_valid;
                    if (r_s1_valid)
                        r_rd_data <= r_s1_data;
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc)
                        r_rd_data <= r_mem[r_rd_ptr];
                end
            end
        end
    endgenerate

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= L_AF);
    assign almost_empty = (r_level <= L_AE);
    assign water_level  = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: drives an OUT_REG=0 and an OUT_REG=1 FIFO with identical
// stimulus and compares both against a queue-based reference model.
module tb_param_sync_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] wr_data = '0;

    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        full_a, full_b, empty_a, empty_b;
    logic        af_a, af_b, ae_a, ae_b;
    logic [4:0]  level_a, level_b;
    logic        ov_a, ov_b, un_a, un_b;

    param_sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .OUT_REG(0),
                      .ALMOST_FULL_NUM(11), .ALMOST_EMPTY_NUM(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .full(full_a),
        .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .water_level(level_a), .overflow(ov_a), .underflow(un_a));

    param_sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .OUT_REG(1),
                      .ALMOST_FULL_NUM(11), .ALMOST_EMPTY_NUM(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .full(full_b),
        .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
        .water_level(level_b), .overflow(ov_b), .underflow(un_b));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    logic [15:0] e0_d, e1_d, p_d;
    logic        e0_v, e1_v, p_v;
    logic        ov_e, un_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e0_d = '0; e0_v = 1'b0;
        e1_d = '0; e1_v = 1'b0;
        p_d  = '0; p_v  = 1'b0;
        ov_e = 1'b0; un_e = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, "/level_a"}, 32'(level_a), 32'(sz));
        chk({tag, "/level_b"}, 32'(level_b), 32'(sz));
        chk({tag, "/full_a"}, 32'(full_a), 32'(sz == 16));
        chk({tag, "/full_b"}, 32'(full_b), 32'(sz == 16));
        chk({tag, "/empty_a"}, 32'(empty_a), 32'(sz == 0));
        chk({tag, "/empty_b"}, 32'(empty_b), 32'(sz == 0));
        chk({tag, "/afull_a"}, 32'(af_a), 32'(sz >= 11));
        chk({tag, "/afull_b"}, 32'(af_b), 32'(sz >= 11));
        chk({tag, "/aempty_a"}, 32'(ae_a), 32'(sz <= 4));
        chk({tag, "/aempty_b"}, 32'(ae_b), 32'(sz <= 4));
        chk({tag, "/ovf_a"}, 32'(ov_a), 32'(ov_e));
        chk({tag, "/ovf_b"}, 32'(ov_b), 32'(ov_e));
        chk({tag, "/unf_a"}, 32'(un_a), 32'(un_e));
        chk({tag, "/unf_b"}, 32'(un_b), 32'(un_e));
        chk({tag, "/rvalid_a"}, 32'(rd_valid_a), 32'(e0_v));
        chk({tag, "/rdata_a"}, 32'(rd_data_a), 32'(e0_d));
        chk({tag, "/rvalid_b"}, 32'(rd_valid_b), 32'(e1_v));
        chk({tag, "/rdata_b"}, 32'(rd_data_b), 32'(e1_d));
    endtask

    // One clock of stimulus; the model is advanced from the pre-edge state.
    task automatic step(input string tag, input logic we, input logic [15:0] wd,
                        input logic re, input logic fl);
        int          sz;
        logic        wacc, racc;
        logic [15:0] word;
        word = '0;
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
        sz   = q.size();
        ov_e = we && sz == 16 && !fl;
        un_e = re && sz == 0 && !fl;
        wacc = we && sz < 16 && !fl;
        racc = re && sz > 0 && !fl;
        if (fl) begin
            q.delete();
            e0_v = 1'b0; e1_v = 1'b0; p_v = 1'b0;
        end else begin
            if (racc) word = q.pop_front();
            if (wacc) q.push_back(wd);
            e0_v = racc;
            if (racc) e0_d = word;
            e1_v = p_v;
            if (p_v) e1_d = p_d;
            p_v = racc;
            if (racc) p_d = word;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        for (int i = 1; i <= 16; i++) step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
        step("overflow", 1'b1, 16'h0011, 1'b0, 1'b0);
        step("after_ovf", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("underflow", 1'b0, '0, 1'b1, 1'b0);
        step("idle1", 1'b0, '0, 1'b0, 1'b0);
        step("idle2", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) step("prefill8", 1'b1, 16'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("concurrent", 1'b1, 16'(200 + i), 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) step("to5", 1'b0, '0, 1'b1, 1'b0);
        step("flush", 1'b1, 16'hDEAD, 1'b0, 1'b1);
        step("post_flush_rd", 1'b0, '0, 1'b1, 1'b0);
        step("post_flush_idle", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) step("fill10", 1'b1, 16'($urandom), 1'b0, 1'b0);
        step("rd_before_rst", 1'b0, '0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_release");
        step("wr_abcd", 1'b1, 16'hABCD, 1'b0, 1'b0);
        step("rd_abcd", 1'b0, '0, 1'b1, 1'b0);
        step("abcd_lat1", 1'b0, '0, 1'b0, 1'b0);
        step("abcd_lat2", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++)
            step("random", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 31) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
